// File: rtl/nco_phase_gen.sv
// NCO phase generator: tuning-word accumulator feeding in-phase and quadrature
// 10-bit phase words to a cosine LUT. Define NCO_PHASE_DITHER_EN for LFSR dither.
module nco_phase_gen #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [ACC_W-1:0] freq_in,
  input  logic             freq_valid,
  output logic             freq_ready,
  input  logic [9:0]       phase_ofs,
  input  logic             sync,
  output logic [9:0]       phase_i,
  output logic [9:0]       phase_q,
  output logic             phase_stb,
  output logic             wrap
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] freq_cur;
  logic [ACC_W-1:0] freq_pend;

  logic [ACC_W:0]   sum_p0;
  logic [ACC_W-1:0] acc_next_p0;
  logic [ACC_W-1:0] acc_dith_p0;
  logic [9:0]       ph_p0;

  // Top 10 accumulator bits plus the static offset, wrapping modulo 1024.
  function automatic logic [9:0] phase_word(input logic [ACC_W-1:0] a,
                                            input logic [9:0]       ofs);
    return a[ACC_W-1 -: 10] + ofs;
  endfunction

  // Stage p0: accumulator step and phase word, combinational.
  always_comb begin
    sum_p0      = {1'b0, acc} + {1'b0, freq_cur};
    acc_next_p0 = sync ? '0 : sum_p0[ACC_W-1:0];
  end

`ifdef NCO_PHASE_DITHER_EN
  localparam int DW = ((ACC_W - 10) > 16) ? 16 : (ACC_W - 10);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0]      lfsr;
  logic [ACC_W-1:0] dith_p0;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  always_comb begin
    dith_p0          = '0;
    dith_p0[DW-1:0]  = lfsr[DW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      lfsr <= LFSR_SEED;
    else if (ce)
      lfsr <= sync ? LFSR_SEED : lfsr_step(lfsr);
  end

  // Dither only perturbs the truncated phase; the accumulator stays exact.
  assign acc_dith_p0 = acc_next_p0 + dith_p0;
`else
  assign acc_dith_p0 = acc_next_p0;
`endif

  assign ph_p0 = phase_word(acc_dith_p0, phase_ofs);

  // Stage p1: registered accumulator, outputs and tuning-word FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      freq_cur   <= '0;
      freq_pend  <= '0;
      freq_ready <= 1'b1;
      phase_i    <= 10'h000;
      phase_q    <= 10'h300;
      phase_stb  <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      if (ce) begin
        acc       <= acc_next_p0;
        wrap      <= sync ? 1'b0 : sum_p0[ACC_W];
        phase_i   <= ph_p0;
        phase_q   <= ph_p0 - 10'd256;
        phase_stb <= 1'b1;
      end else begin
        phase_stb <= 1'b0;
        wrap      <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (freq_valid) begin
            // A stalled oscillator has no wrap to wait for, so load at once.
            if (freq_cur == '0) begin
              freq_cur <= freq_in;
            end else begin
              freq_pend  <= freq_in;
              state      <= PEND;
              freq_ready <= 1'b0;
            end
          end
        end
        PEND: begin
          if (ce && (sync || sum_p0[ACC_W])) begin
            freq_cur   <= freq_pend;
            state      <= IDLE;
            freq_ready <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          freq_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/nco_phase_gen.md
Name: nco_phase_gen

Overview:
- Numerically controlled oscillator phase generator.
- Sits directly upstream of the 10-bit-phase / 8-bit-signed quarter-wave cosine LUT used for test tones and video/audio pattern generators.
- Produces an in-phase and a quadrature 10-bit phase word per sample enable. Feeding the quadrature word into a second LUT instance yields sine.
- Frequency changes arrive over a valid/ready handshake and are applied phase-continuously at accumulator wrap.

Parameters:
- ACC_W, 24, accumulator width in bits. Legal range 12..32. The top 10 bits form the phase.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  sample enable; the accumulator advances only when high
- freq_in  in  ACC_W  requested tuning word
- freq_valid  in  1  freq_in valid
- freq_ready  out  1  block can accept a new tuning word
- phase_ofs  in  10  static phase offset added to both outputs
- sync  in  1  phase-restart request, sampled on ce cycles only
- phase_i  out  10  in-phase phase word to the cosine LUT
- phase_q  out  10  phase_i - 256 mod 1024 (cos of this = sin of phase_i)
- phase_stb  out  1  one-cycle strobe: phase_i/phase_q updated this cycle
- wrap  out  1  one-cycle strobe: accumulator overflowed on this step

Behaviour:
- Reset values: acc=0, freq_cur=0, freq_pend=0, state=IDLE, phase_i=0, phase_q=10'h300, phase_stb=0, wrap=0, freq_ready=1.
- Reset is honoured mid-operation at any time; any pending word is discarded.
- FSM states:
  - IDLE: no pending word; freq_ready=1.
  - PEND: word held in freq_pend; freq_ready=0.
- Transitions:
  - IDLE -> PEND when freq_valid & freq_ready. freq_in is latched into freq_pend.
  - Exception: if freq_cur==0 (oscillator stalled), the word loads directly into freq_cur the same cycle, and state stays IDLE.
  - PEND -> IDLE on the first ce step whose sum overflows (carry out of ACC_W) or on a sync step. freq_cur<=freq_pend takes effect from the following step.
- freq_valid while freq_ready=0 is ignored. The source must hold the word until accepted.
- Step rules (ce=1):
  - sum = acc + freq_cur, ACC_W+1 bits.
  - acc <= sum[ACC_W-1:0]; wrap <= sum[ACC_W].
- Sync rules (ce=1 & sync):
  - acc <= 0; wrap <= 0; pending word, if any, is applied.
  - sync overrides the step.
- ce=0: acc, freq_cur and phase outputs hold; phase_stb=0; wrap=0.
- Outputs are registered. On a ce edge:
  - phase_i <= acc_next[ACC_W-1 -: 10] + phase_ofs (mod 1024).
  - phase_q <= that value - 256 (mod 1024).
  - phase_stb <= 1.
  - Latency: phase reflects acc_next in the cycle after ce, with no extra pipeline. The LUT stage is combinational downstream.
- Back-to-back ce every cycle is supported at full rate.
- Simultaneous freq_valid handshake and wrap in the same cycle, in IDLE: the word is latched into pend. It applies at the next wrap, not the current one.
- phase_ofs changes take effect on the next ce step. They are not synchronised to wrap.

Optional Feature:
- Macro: NCO_PHASE_DITHER_EN.
- Defined:
  - A 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances once per ce.
  - Its low (ACC_W-10) bits, capped at 16, are added to acc_next before truncation to 10 bits. This spreads truncation spurs.
  - acc itself is never dithered.
  - sync reseeds the LFSR to 16'hACE1.
- Undefined: plain truncation. No LFSR logic is present.

Test Plan:
- Reset -> phase_i=0, phase_q=0x300, freq_ready=1, phase_stb=0, wrap=0.
- Initial load (ACC_W=24): freq_in=0x040000 while freq_cur=0, ce every cycle -> word loads immediately; phase_i steps 16,32,…; wrap pulses every 64 ce; phase_q = phase_i-256 mod 1024.
- Phase-continuous change: running at 0x040000, write 0x080000 mid-period -> freq_ready drops; the step size stays 16 until the wrap pulse, then becomes 32; freq_ready returns to 1 at the wrap edge.
- Sync: sync with ce at phase 480, phase_ofs=0 -> next phase_i=0, wrap=0, pending word applied; with phase_ofs=100 -> phase_i=100.
- ce gating: ce low 10 cycles mid-run -> outputs frozen, phase_stb=0, no wrap; resumes from the same phase.
- Async reset asserted between clock edges while in PEND -> all outputs take reset values immediately; pending word lost; freq_ready=1.
